// File: rtl/cl_dma_pcis_slv.sv
`default_nettype none
// ============================================================================
// Module   : cl_dma_pcis_slv
// Purpose  : AXI4 responder for the shell-to-CL DMA PCIS bus. Accepts INCR
//            bursts of 64-byte beats and backs them with an on-chip memory of
//            DEPTH 512-bit words located at BASE_ADDR.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   aclk, areset          : clock, asynchronous active-high reset
//   aw*_i / awready_o     : write address channel (id, addr, len)
//   w*_i  / wready_o      : write data channel (data, strobe, last)
//   b*_o  / bready_i      : write response channel (id, resp)
//   ar*_i / arready_o     : read address channel (id, addr, len)
//   r*_o  / rready_i      : read data channel (id, data, resp, last)
//   wr_err_cnt_o          : saturating count of write bursts answered SLVERR
//   rd_err_cnt_o          : saturating count of read bursts with an SLVERR beat
// ============================================================================
module cl_dma_pcis_slv #(
    parameter int          DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic           aclk,
    input  logic           areset,
    // Write address channel
    input  logic [5:0]     awid_i,
    input  logic [63:0]    awaddr_i,
    input  logic [7:0]     awlen_i,
    input  logic           awvalid_i,
    output logic           awready_o,
    // Write data channel
    input  logic [511:0]   wdata_i,
    input  logic [63:0]    wstrb_i,
    input  logic           wlast_i,
    input  logic           wvalid_i,
    output logic           wready_o,
    // Write response channel
    output logic [5:0]     bid_o,
    output logic [1:0]     bresp_o,
    output logic           bvalid_o,
    input  logic           bready_i,
    // Read address channel
    input  logic [5:0]     arid_i,
    input  logic [63:0]    araddr_i,
    input  logic [7:0]     arlen_i,
    input  logic           arvalid_i,
    output logic           arready_o,
    // Read data channel
    output logic [5:0]     rid_o,
    output logic [511:0]   rdata_o,
    output logic [1:0]     rresp_o,
    output logic           rlast_o,
    output logic           rvalid_o,
    input  logic           rready_i,
    // Error statistics
    output logic [15:0]    wr_err_cnt_o,
    output logic [15:0]    rd_err_cnt_o
);

    localparam int          AW          = $clog2(DEPTH);
    // Addresses are tracked as 58-bit beat numbers; the low 6 bits never matter.
    localparam logic [57:0] BASE_BEAT   = BASE_ADDR[63:6];
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } rd_state_t;

    // ------------------------------------------------------------------
    // Storage (contents deliberately not reset)
    // ------------------------------------------------------------------
    logic [511:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wr_state_t    wr_state_q;
    logic [5:0]   wr_id_q;
    logic [57:0]  wr_beat_q;
    logic [7:0]   wr_len_q;
    logic [7:0]   wr_cnt_q;
    logic         wr_err_q;
    logic         awready_q;
    logic         wready_q;
    logic         bvalid_q;
    logic [5:0]   bid_q;
    logic [1:0]   bresp_q;
    logic [15:0]  wr_err_cnt_q;

    logic [57:0]  wr_off;
    logic         wr_in_range;
    logic [AW-1:0] wr_idx;
    logic         w_hs;
    logic         wr_cnt_match;
    logic         w_end;
    logic         wr_err_d;
    logic         mem_we;

    // Subtraction wraps for addresses below the base, which pushes them
    // into the upper bits and so out of range as well.
    assign wr_off       = wr_beat_q - BASE_BEAT;
    assign wr_in_range  = (wr_off[57:AW] == '0);
    assign wr_idx       = wr_off[AW-1:0];
    assign w_hs         = wready_q & wvalid_i;
    assign wr_cnt_match = (wr_cnt_q == wr_len_q);
    // The burst closes on whichever comes first: wlast or the awlen count.
    assign w_end        = wlast_i | wr_cnt_match;
    // Error if this beat is out of range or wlast disagrees with the count.
    assign wr_err_d     = wr_err_q | ~wr_in_range | (wlast_i ^ wr_cnt_match);
    assign mem_we       = w_hs & wr_in_range;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q   <= W_IDLE;
            wr_id_q      <= '0;
            wr_beat_q    <= '0;
            wr_len_q     <= '0;
            wr_cnt_q     <= '0;
            wr_err_q     <= 1'b0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= RESP_OKAY;
            wr_err_cnt_q <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awvalid_i && awready_q) begin
                        wr_id_q    <= awid_i;
                        wr_beat_q  <= awaddr_i[63:6];
                        wr_len_q   <= awlen_i;
                        wr_cnt_q   <= '0;
                        wr_err_q   <= 1'b0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_err_q <= wr_err_d;
                        if (w_end) begin
                            wready_q   <= 1'b0;
                            bvalid_q   <= 1'b1;
                            bid_q      <= wr_id_q;
                            bresp_q    <= wr_err_d ? RESP_SLVERR : RESP_OKAY;
                            wr_state_q <= W_RESP;
                        end else begin
                            wr_beat_q <= wr_beat_q + 58'd1;
                            wr_cnt_q  <= wr_cnt_q + 8'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                        if (wr_err_q && (wr_err_cnt_q != CNT_MAX)) begin
                            wr_err_cnt_q <= wr_err_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-granular write port; out-of-range beats never reach the array.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 64; b++) begin
                if (wstrb_i[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rd_state_t    rd_state_q;
    logic [5:0]   rd_id_q;
    logic [57:0]  rd_beat_q;
    logic [7:0]   rd_len_q;
    logic [7:0]   rd_cnt_q;
    logic         rd_err_q;
    logic         arready_q;
    logic         rvalid_q;
    logic         rlast_q;
    logic [5:0]   rid_q;
    logic [511:0] rdata_q;
    logic [1:0]   rresp_q;
    logic [15:0]  rd_err_cnt_q;

    logic [57:0]  rd_off;
    logic         rd_in_range;
    logic [AW-1:0] rd_idx;

    assign rd_off      = rd_beat_q - BASE_BEAT;
    assign rd_in_range = (rd_off[57:AW] == '0);
    assign rd_idx      = rd_off[AW-1:0];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_state_q   <= R_IDLE;
            rd_id_q      <= '0;
            rd_beat_q    <= '0;
            rd_len_q     <= '0;
            rd_cnt_q     <= '0;
            rd_err_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rid_q        <= '0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            rd_err_cnt_q <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arvalid_i && arready_q) begin
                        rd_id_q    <= arid_i;
                        rd_beat_q  <= araddr_i[63:6];
                        rd_len_q   <= arlen_i;
                        rd_cnt_q   <= '0;
                        rd_err_q   <= 1'b0;
                        arready_q  <= 1'b0;
                        rd_state_q <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // A write landing on the same word this cycle is not
                    // visible yet, so the read sees the previous contents.
                    rdata_q    <= rd_in_range ? mem[rd_idx] : '0;
                    rresp_q    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rd_err_q   <= rd_err_q | ~rd_in_range;
                    rlast_q    <= (rd_cnt_q == rd_len_q);
                    rid_q      <= rd_id_q;
                    rvalid_q   <= 1'b1;
                    rd_state_q <= R_DATA;
                end
                R_DATA: begin
                    if (rready_i) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q  <= 1'b1;
                            rd_state_q <= R_IDLE;
                            if (rd_err_q && (rd_err_cnt_q != CNT_MAX)) begin
                                rd_err_cnt_q <= rd_err_cnt_q + 16'd1;
                            end
                        end else begin
                            rd_beat_q  <= rd_beat_q + 58'd1;
                            rd_cnt_q   <= rd_cnt_q + 8'd1;
                            rd_state_q <= R_FETCH;
                        end
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // Sub-beat address bits carry no meaning for 64-byte beats.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr_i[5:0], araddr_i[5:0]};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign awready_o    = awready_q;
    assign wready_o     = wready_q;
    assign bvalid_o     = bvalid_q;
    assign bid_o        = bid_q;
    assign bresp_o      = bresp_q;
    assign arready_o    = arready_q;
    assign rvalid_o     = rvalid_q;
    assign rlast_o      = rlast_q;
    assign rid_o        = rid_q;
    assign rdata_o      = rdata_q;
    assign rresp_o      = rresp_q;
    assign wr_err_cnt_o = wr_err_cnt_q;
    assign rd_err_cnt_o = rd_err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cl_dma_pcis_slv.sv
`default_nettype none
// ============================================================================
// Module   : tb_cl_dma_pcis_slv
// Purpose  : Self-checking bench for cl_dma_pcis_slv. A word-array reference
//            model tracks memory contents and error counts; directed vectors,
//            hand-written corner sequences and random bursts are compared
//            against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cl_dma_pcis_slv;

    localparam int DEPTH = 1024;

    logic         aclk   = 1'b0;
    logic         areset = 1'b1;
    logic [5:0]   awid = '0;    logic [63:0] awaddr = '0; logic [7:0] awlen = '0;
    logic         awvalid = 1'b0; logic awready;
    logic [511:0] wdata = '0;   logic [63:0] wstrb = '0;
    logic         wlast = 1'b0; logic wvalid = 1'b0; logic wready;
    logic [5:0]   bid;          logic [1:0] bresp; logic bvalid; logic bready = 1'b0;
    logic [5:0]   arid = '0;    logic [63:0] araddr = '0; logic [7:0] arlen = '0;
    logic         arvalid = 1'b0; logic arready;
    logic [5:0]   rid;          logic [511:0] rdata; logic [1:0] rresp;
    logic         rlast;        logic rvalid; logic rready = 1'b0;
    logic [15:0]  wr_err_cnt;   logic [15:0] rd_err_cnt;

    cl_dma_pcis_slv #(.DEPTH(DEPTH), .BASE_ADDR(64'h0)) dut (
        .aclk(aclk), .areset(areset),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready),
        .wr_err_cnt_o(wr_err_cnt), .rd_err_cnt_o(rd_err_cnt)
    );

    always #5 aclk = ~aclk;

    // Reference model: plain word array plus expected error counts
    logic [511:0] model_mem [DEPTH];
    int           exp_wr_err = 0;
    int           exp_rd_err = 0;
    logic [511:0] wbuf_data [256];
    logic [63:0]  wbuf_strb [256];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // Full write burst: model update, AW, W beats, B with optional hold.
    task automatic axi_write(input logic [5:0] id, input logic [63:0] addr, input int len,
                             input int wlast_beat, input int bhold, output logic [1:0] got_bresp);
        int         last;
        bit         err;
        int         k;
        logic [63:0] idx;
        logic [1:0] exp_resp;
        got_bresp = 2'bxx;
        last = (wlast_beat >= 0 && wlast_beat < len) ? wlast_beat : len;
        err  = (wlast_beat != len);
        for (int i = 0; i <= last; i++) begin
            idx = (addr >> 6) + 64'(i);
            if (idx < 64'(DEPTH)) begin
                for (int b = 0; b < 64; b++)
                    if (wbuf_strb[i][b]) model_mem[idx[9:0]][b*8 +: 8] = wbuf_data[i][b*8 +: 8];
            end else begin
                err = 1'b1;
            end
        end
        exp_resp = err ? 2'b10 : 2'b00;
        if (err && exp_wr_err < 65535) exp_wr_err++;

        awid = id; awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin tick(); k++; end
        if (!awready) begin awvalid = 1'b0; timeout_fail("aw_handshake"); return; end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= last; i++) begin
            wvalid = 1'b1; wdata = wbuf_data[i]; wstrb = wbuf_strb[i]; wlast = (i == wlast_beat);
            k = 0;
            while (!wready && k < 50) begin tick(); k++; end
            if (!wready) begin wvalid = 1'b0; wlast = 1'b0; timeout_fail("w_beat"); return; end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("wready_after_burst", wready, 1'b0);
        k = 0;
        while (!bvalid && k < 50) begin tick(); k++; end
        if (!bvalid) begin timeout_fail("bvalid_wait"); return; end
        for (int h = 0; h < bhold; h++) begin
            check("bvalid_hold", bvalid, 1'b1);
            check("bid_hold", bid, id);
            check("bresp_hold", bresp, exp_resp);
            check("awready_during_b", awready, 1'b0);
            tick();
        end
        check("bid", bid, id);
        check("bresp", bresp, exp_resp);
        got_bresp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_drop", bvalid, 1'b0);
        check("wr_err_cnt", wr_err_cnt, 16'(exp_wr_err));
    endtask

    // Full read burst compared beat by beat against the model.
    task automatic axi_read(input logic [5:0] id, input logic [63:0] addr, input int len,
                            input bit rand_rready, output logic [1:0] last_rresp,
                            output logic [511:0] last_rdata);
        logic [511:0] exp_d;
        logic [1:0]   exp_r;
        logic [63:0]  idx;
        bit           err;
        int           k;
        int           hold;
        err = 1'b0; last_rresp = 2'bxx; last_rdata = 'x;
        arid = id; araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin tick(); k++; end
        if (!arready) begin arvalid = 1'b0; timeout_fail("ar_handshake"); return; end
        tick();
        arvalid = 1'b0;
        check("rvalid_in_fetch", rvalid, 1'b0);
        for (int i = 0; i <= len; i++) begin
            idx = (addr >> 6) + 64'(i);
            if (idx < 64'(DEPTH)) begin exp_d = model_mem[idx[9:0]]; exp_r = 2'b00; end
            else begin exp_d = '0; exp_r = 2'b10; err = 1'b1; end
            if (i == 0) begin
                tick();
                check("first_rvalid_latency", rvalid, 1'b1);
            end
            k = 0;
            while (!rvalid && k < 10) begin tick(); k++; end
            if (!rvalid) begin timeout_fail("rvalid_wait"); return; end
            if (rand_rready) begin
                hold = $urandom_range(0, 3);
                for (int h = 0; h < hold; h++) begin
                    rready = 1'b0;
                    tick();
                    check("rvalid_hold", rvalid, 1'b1);
                    check("rdata_hold", rdata, exp_d);
                    check("rlast_hold", rlast, (i == len));
                end
            end
            check("rdata", rdata, exp_d);
            check("rresp", rresp, exp_r);
            check("rid", rid, id);
            check("rlast", rlast, (i == len));
            last_rresp = rresp;
            last_rdata = rdata;
            rready = 1'b1;
            tick();
            rready = 1'b0;
            check("rvalid_drop", rvalid, 1'b0);
        end
        if (err && exp_rd_err < 65535) exp_rd_err++;
        check("rd_err_cnt", rd_err_cnt, 16'(exp_rd_err));
    endtask

    typedef struct {
        logic [5:0]  id;
        logic [63:0] addr;
        int          len;
        logic [63:0] strb;
        int          mode;          // 0: beat-index bytes, 1: all ones, 2: random
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_last_rresp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [1:0]   gb;
        logic [1:0]   gr;
        logic [511:0] gd;
        logic [511:0] old_v;
        logic [511:0] new_v;
        int           k;
        int           len;
        int           wl;
        logic [63:0]  a;

        vecs[0] = '{6'd3,  64'h0,     3, '1,                    0, 2'b00, 2'b00};
        vecs[1] = '{6'd7,  64'h140,   0, '1,                    1, 2'b00, 2'b00};
        vecs[2] = '{6'd8,  64'h140,   0, 64'h00000000_0000000F, 2, 2'b00, 2'b00};
        vecs[3] = '{6'd9,  64'hFFC0,  1, '1,                    2, 2'b10, 2'b10};
        vecs[4] = '{6'd1,  64'h213,   2, '1,                    2, 2'b00, 2'b00};
        vecs[5] = '{6'h3F, 64'h10000, 0, '1,                    2, 2'b10, 2'b10};
        vecs[6] = '{6'd2,  64'hFF80,  3, 64'hF0F0_F0F0_0F0F_0F0F, 2, 2'b10, 2'b10};

        // Reset state
        tick(); tick();
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_bid", bid, 6'd0);
        check("rst_rid", rid, 6'd0);
        check("rst_rdata", rdata, '0);
        check("rst_wr_err_cnt", wr_err_cnt, 16'd0);
        check("rst_rd_err_cnt", rd_err_cnt, 16'd0);
        areset = 1'b0;
        tick();
        check("idle_awready", awready, 1'b1);
        check("idle_arready", arready, 1'b1);

        // Give every word a known value so later reads are fully predictable
        for (int blk = 0; blk < DEPTH / 256; blk++) begin
            for (int i = 0; i < 256; i++) begin
                wbuf_data[i] = {16{32'(blk * 256 + i)}};
                wbuf_strb[i] = '1;
            end
            axi_write(6'd0, 64'(blk * 256 * 64), 255, 255, 0, gb);
        end

        // Directed vectors
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i <= vecs[t].len; i++) begin
                case (vecs[t].mode)
                    0:       wbuf_data[i] = {64{8'(i)}};
                    1:       wbuf_data[i] = '1;
                    default: for (int j = 0; j < 16; j++) wbuf_data[i][j*32 +: 32] = $urandom;
                endcase
                wbuf_strb[i] = vecs[t].strb;
            end
            axi_write(vecs[t].id, vecs[t].addr, vecs[t].len, vecs[t].len, (t == 0) ? 10 : 0, gb);
            check("vec_bresp", gb, vecs[t].exp_bresp);
            axi_read(vecs[t].id + 6'd1, vecs[t].addr, vecs[t].len, (t % 2) == 1, gr, gd);
            check("vec_last_rresp", gr, vecs[t].exp_last_rresp);
        end

        // Partial strobe: only bytes 0-3 of word 5 changed over all-ones
        axi_read(6'd4, 64'h140, 0, 1'b0, gr, gd);
        check("strb_upper_bytes_kept", gd[511:32], {480{1'b1}});

        // wlast earlier than awlen, then missing wlast
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 16; j++) wbuf_data[i][j*32 +: 32] = $urandom;
            wbuf_strb[i] = '1;
        end
        axi_write(6'd4, 64'h400, 3, 1, 0, gb);
        check("early_wlast_bresp", gb, 2'b10);
        axi_write(6'd5, 64'h400, 1, -1, 0, gb);
        check("missing_wlast_bresp", gb, 2'b10);
        axi_read(6'd6, 64'h400, 3, 1'b1, gr, gd);

        // Concurrent write and read of word 8 on the same edge
        old_v = model_mem[8];
        for (int j = 0; j < 16; j++) new_v[j*32 +: 32] = $urandom;
        awid = 6'd10; awaddr = 64'h200; awlen = 8'd0; awvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin tick(); k++; end
        if (!awready) timeout_fail("conc_aw");
        tick();
        awvalid = 1'b0;
        arid = 6'd11; araddr = 64'h200; arlen = 8'd0; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 50) begin tick(); k++; end
        if (!arready) timeout_fail("conc_ar");
        tick();
        arvalid = 1'b0;
        check("conc_wready", wready, 1'b1);
        wvalid = 1'b1; wdata = new_v; wstrb = '1; wlast = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        model_mem[8] = new_v;
        check("conc_rvalid", rvalid, 1'b1);
        check("conc_rdata_old", rdata, old_v);
        check("conc_bvalid", bvalid, 1'b1);
        check("conc_bresp", bresp, 2'b00);
        check("conc_bid", bid, 6'd10);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check("conc_bvalid_drop", bvalid, 1'b0);
        check("conc_rvalid_drop", rvalid, 1'b0);
        axi_read(6'd12, 64'h200, 0, 1'b0, gr, gd);
        check("conc_rdata_new", gd, new_v);

        // Random bursts, occasionally running off the end or with bad wlast
        for (int t = 0; t < 20; t++) begin
            a   = 64'($urandom_range(0, DEPTH + 4)) * 64 + 64'($urandom_range(0, 63));
            len = $urandom_range(0, 7);
            wl  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : len;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 16; j++) wbuf_data[i][j*32 +: 32] = $urandom;
                wbuf_strb[i] = {$urandom, $urandom};
            end
            axi_write(6'($urandom), a, len, wl, $urandom_range(0, 3), gb);
            axi_read(6'($urandom), a, len, 1'b1, gr, gd);
        end

        // Reset during beat 2 of a 4-beat burst to word 20
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++) wbuf_data[i][j*32 +: 32] = $urandom;
        awid = 6'd13; awaddr = 64'(20 * 64); awlen = 8'd3; awvalid = 1'b1;
        k = 0;
        while (!awready && k < 50) begin tick(); k++; end
        if (!awready) timeout_fail("rst_aw");
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = wbuf_data[i]; wstrb = '1; wlast = 1'b0;
            k = 0;
            while (!wready && k < 50) begin tick(); k++; end
            if (!wready) timeout_fail("rst_w");
            tick();
            model_mem[20 + i] = wbuf_data[i];
        end
        wdata = wbuf_data[2];
        check("rst_beat2_wready", wready, 1'b1);
        areset = 1'b1;
        #1;
        check("midrst_awready", awready, 1'b0);
        check("midrst_wready", wready, 1'b0);
        check("midrst_bvalid", bvalid, 1'b0);
        wvalid = 1'b0;
        exp_wr_err = 0;
        exp_rd_err = 0;
        tick(); tick();
        areset = 1'b0;
        tick();
        check("post_rst_awready", awready, 1'b1);
        check("post_rst_wr_err_cnt", wr_err_cnt, 16'd0);
        check("post_rst_rd_err_cnt", rd_err_cnt, 16'd0);
        for (int h = 0; h < 3; h++) begin
            check("post_rst_no_b", bvalid, 1'b0);
            tick();
        end
        axi_read(6'd14, 64'(20 * 64), 3, 1'b0, gr, gd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cl_dma_pcis_slv.md
Name: cl_dma_pcis_slv

Overview:
- AXI4 responder (slave end) for the shell-to-CL DMA PCIS interface: accepts shell-initiated INCR burst writes and reads.
- Backs them with an on-chip 512-bit-wide memory.
- Sits in the CL directly on sh_cl_dma_pcis_q (downstream of the register slice), alongside the debug ILA that probes the same bus.
- Gives host DMA a deterministic target for bring-up and loopback tests.

Parameters:
- DEPTH, 1024, number of 512-bit memory words (power of two, 16..4096).
- BASE_ADDR, 64'h0, byte address of word 0; must be aligned to DEPTH*64.

Ports:
- aclk  input  1  sole clock; all logic rising-edge.
- areset  input  1  asynchronous, active-high reset.
- sh_cl_dma_pcis_q  axi_bus_t (slave side)  -  AXI4 channels used:
  - AW: awid[5:0], awaddr[63:0], awlen[7:0], awvalid/awready.
  - W: wdata[511:0], wstrb[63:0], wlast, wvalid/wready.
  - B: bid, bresp[1:0], bvalid/bready.
  - AR: arid, araddr, arlen, arvalid/arready.
  - R: rid, rdata[511:0], rresp, rlast, rvalid/rready.
- wr_err_cnt  output  16  saturating count of SLVERR write bursts.
- rd_err_cnt  output  16  saturating count of SLVERR read bursts.

Behaviour:
- Reset (async assert, sync release): all outputs and FSMs go to 0/IDLE — awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rid, bid, rdata, err counts. Memory contents are not reset.
- Only INCR 64-byte beats are supported. awsize/arsize/awburst/arburst are ignored. Low 6 address bits are ignored (beat aligned).
- Beat index = (addr - BASE_ADDR) >> 6. A beat is in range iff index < DEPTH; checked per beat, so a burst may run off the end.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&awready, latch awid, start address, awlen; clear err flag; go to W_DATA (awready=0).
  - W_DATA: wready=1. Each wvalid&wready beat writes the memory byte-wise per wstrb if in range; otherwise the beat is dropped and err flag set. Address +64 per beat.
  - On the beat where wlast=1 OR beat count==awlen: go to W_RESP. A wlast/count mismatch sets the err flag; data beats after a count match are not accepted in this burst.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 if err else 2'b00. Hold until bready. Then W_IDLE; wr_err_cnt+1 if err (saturate at 16'hFFFF).
- Read FSM:
  - R_IDLE: arready=1. On handshake, latch arid, address, arlen; go to R_FETCH.
  - R_FETCH: issue synchronous memory read (1-cycle latency); go to R_DATA.
  - R_DATA: rvalid=1, rdata=mem word (zero if out of range, and err flag set), rresp=10 if that beat is out of range else 00, rid=latched id, rlast=1 on beat arlen.
  - On rvalid&rready: if last, go to R_IDLE and bump rd_err_cnt if any beat erred; else advance address and go to R_FETCH.
  - rvalid/rdata stable while rready=0. Throughput is 1 beat per 2 cycles; first rvalid is 2 cycles after AR handshake.
- Read and write FSMs are independent and may run concurrently. Same-word write and read in one cycle: read returns old data.
- One outstanding transaction per direction; no ID reordering.
- Reset mid-burst: FSMs return to IDLE immediately, partial writes already committed stay, no B/R response is issued.

Test Plan:
- Write awaddr=0x0, awlen=3, wstrb all-1, data=beat index pattern -> 4 wready beats, bvalid with bresp=00, bid=awid. Then read araddr=0x0, arlen=3 -> rdata matches, rlast on 4th beat, rid=arid, first rvalid 2 cycles after arvalid&arready.
- Partial strobe: write word 5 with wstrb=64'h00000000_0000000F over prior all-FF data -> read back shows only bytes 0-3 updated.
- Boundary: DEPTH=1024, write awaddr=0xFFC0, awlen=1 -> beat 0 written, beat 1 dropped, bresp=10, wr_err_cnt=1. Read same range -> beat 1 rdata=0, rresp=10, rd_err_cnt=1.
- Backpressure: hold bready=0 for 10 cycles and toggle rready randomly -> bvalid/bid/bresp and rvalid/rdata/rlast stable until handshake; awready stays 0 until B completes.
- Concurrent write to word 8 while reading word 8 in the same cycle -> read returns pre-write value; a following read returns new value.
- Assert areset during W_DATA beat 2 of a 4-beat burst -> awready/wready/bvalid=0 at once, no B response. After release, awready=1, and beats 0-1 are present in memory.
